// File: rtl/playback_ctrl.sv
// Music-box playback sequencer: STOP/PLAY/PAUSE control, song selection,
// once-per-second tick generation and song-position tracking.
module playback_ctrl #(
  parameter int CLK_HZ    = 100_000_000,
  parameter int SONG0_LEN = 95,
  parameter int SONG1_LEN = 130
) (
  input  logic       clk,
  input  logic       RESET_N,
  input  logic       play_btn,
  input  logic       next_btn,
  input  logic       stop_btn,
  input  logic       autoplay,
  output logic       song_sel,
  output logic       ispaused,
  output logic       tick,
  output logic       time_clr,
  output logic       song_end,
  output logic [7:0] pos_s,
  output logic [1:0] state
);

  localparam int               PW        = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [PW-1:0]    PRESC_MAX = PW'(CLK_HZ - 1);
  localparam logic [7:0]       LAST0     = 8'(SONG0_LEN - 1);
  localparam logic [7:0]       LAST1     = 8'(SONG1_LEN - 1);

  typedef enum logic [1:0] {
    ST_STOP  = 2'b00,
    ST_PLAY  = 2'b01,
    ST_PAUSE = 2'b10
  } state_t;

  state_t        cur, nxt;
  logic [PW-1:0] presc, presc_nxt;
  logic          song_nxt;
  logic [7:0]    pos_nxt;
  logic [7:0]    last_pos;
  logic          tick_nxt, clr_nxt, end_nxt;

  always_ff @(posedge clk or negedge RESET_N) begin
    if (!RESET_N) begin
      cur      <= ST_STOP;
      presc    <= '0;
      song_sel <= 1'b0;
      pos_s    <= '0;
      tick     <= 1'b0;
      time_clr <= 1'b0;
      song_end <= 1'b0;
      ispaused <= 1'b1;
    end else begin
      cur      <= nxt;
      presc    <= presc_nxt;
      song_sel <= song_nxt;
      pos_s    <= pos_nxt;
      tick     <= tick_nxt;
      time_clr <= clr_nxt;
      song_end <= end_nxt;
      ispaused <= (nxt != ST_PLAY);
    end
  end

  assign state = cur;

  // Buttons are mutually exclusive by priority; any acting button also
  // suppresses the prescaler wrap on that edge.
  always_comb begin
    nxt       = cur;
    presc_nxt = presc;
    song_nxt  = song_sel;
    pos_nxt   = pos_s;
    tick_nxt  = 1'b0;
    clr_nxt   = 1'b0;
    end_nxt   = 1'b0;
    last_pos  = song_sel ? LAST1 : LAST0;

    if (stop_btn) begin
      nxt       = ST_STOP;
      pos_nxt   = '0;
      presc_nxt = '0;
      clr_nxt   = 1'b1;
    end else if (next_btn) begin
      song_nxt  = ~song_sel;
      pos_nxt   = '0;
      presc_nxt = '0;
      clr_nxt   = 1'b1;
    end else if (play_btn) begin
      nxt = (cur == ST_PLAY) ? ST_PAUSE : ST_PLAY;
    end else begin
      case (cur)
        ST_PLAY: begin
          if (presc == PRESC_MAX) begin
            presc_nxt = '0;
            tick_nxt  = 1'b1;
            if (pos_s == last_pos) begin
              pos_nxt = '0;
              end_nxt = 1'b1;
              clr_nxt = 1'b1;
              if (autoplay) song_nxt = ~song_sel;
              else          nxt      = ST_STOP;
            end else begin
              pos_nxt = pos_s + 8'd1;
            end
          end else begin
            presc_nxt = presc + 1'b1;
          end
        end
        ST_PAUSE: presc_nxt = presc;
        default:  presc_nxt = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_playback_ctrl.sv
// Randomized and directed bench for playback_ctrl; pulse outputs are checked
// by a queue-based scoreboard fed from a second-level reference model.
module tb_playback_ctrl;

  localparam int CLK_HZ = 4;
  localparam int L0     = 3;
  localparam int L1     = 5;

  logic       clk = 1'b0;
  logic       RESET_N = 1'b0;
  logic       play_btn = 1'b0, next_btn = 1'b0, stop_btn = 1'b0, autoplay = 1'b0;
  logic       song_sel, ispaused, tick, time_clr, song_end;
  logic [7:0] pos_s;
  logic [1:0] state;

  playback_ctrl #(.CLK_HZ(CLK_HZ), .SONG0_LEN(L0), .SONG1_LEN(L1)) dut (
    .clk(clk), .RESET_N(RESET_N), .play_btn(play_btn), .next_btn(next_btn),
    .stop_btn(stop_btn), .autoplay(autoplay), .song_sel(song_sel),
    .ispaused(ispaused), .tick(tick), .time_clr(time_clr), .song_end(song_end),
    .pos_s(pos_s), .state(state)
  );

  always #5 clk = ~clk;

  typedef struct {
    int cyc;
    bit t;
    bit c;
    bit e;
    int pos;
    int song;
    int st;
  } ev_t;

  ev_t q[$];
  int  checks = 0;
  int  errors = 0;
  int  cyc = 0;

  // Reference model: 0 stop, 1 play, 2 pause; phase = cycles into current second
  int m_st, m_song, m_pos, m_phase;
  bit m_auto;

  always @(posedge clk) cyc = cyc + 1;

  function automatic int song_len(int s);
    return (s != 0) ? L1 : L0;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    checks = checks + 1;
    if (act != exp) begin
      errors = errors + 1;
      $display("FAIL %s at cycle %0d: actual %0d required %0d", nm, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    m_st = 0; m_song = 0; m_pos = 0; m_phase = 0;
  endtask

  // Called at a negedge: verify the previous edge, drive inputs, predict the next edge.
  task automatic step(input bit p, input bit n, input bit s);
    ev_t ev;
    chk("state", int'(state), m_st);
    chk("pos_s", int'(pos_s), m_pos);
    chk("song_sel", int'(song_sel), m_song);
    chk("ispaused", int'(ispaused), int'(m_st != 1));
    play_btn = p; next_btn = n; stop_btn = s; autoplay = m_auto;
    ev = '{cyc: cyc + 1, t: 0, c: 0, e: 0, pos: 0, song: 0, st: 0};
    if (s) begin
      m_st = 0; m_pos = 0; m_phase = 0; ev.c = 1;
    end else if (n) begin
      m_song = 1 - m_song; m_pos = 0; m_phase = 0; ev.c = 1;
    end else if (p) begin
      m_st = (m_st == 1) ? 2 : 1;
    end else if (m_st == 1) begin
      m_phase = m_phase + 1;
      if (m_phase == CLK_HZ) begin
        m_phase = 0;
        ev.t = 1;
        m_pos = m_pos + 1;
        if (m_pos == song_len(m_song)) begin
          m_pos = 0; ev.e = 1; ev.c = 1;
          if (m_auto) m_song = 1 - m_song;
          else        m_st = 0;
        end
      end
    end
    ev.pos = m_pos; ev.song = m_song; ev.st = m_st;
    if (ev.t || ev.c || ev.e) q.push_back(ev);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0);
  endtask

  task automatic run_to_pos(input int p);
    for (int i = 0; i < 100 && m_pos != p; i++) step(0, 0, 0);
    chk("reach_pos", m_pos, p);
  endtask

  task automatic check_reset_vals();
    chk("rst_state", int'(state), 0);
    chk("rst_song", int'(song_sel), 0);
    chk("rst_ispaused", int'(ispaused), 1);
    chk("rst_tick", int'(tick), 0);
    chk("rst_clr", int'(time_clr), 0);
    chk("rst_end", int'(song_end), 0);
    chk("rst_pos", int'(pos_s), 0);
  endtask

  // Reset asserted between edges; outputs must clear before the next edge.
  task automatic reset_mid();
    play_btn = 0; next_btn = 0; stop_btn = 0;
    #2 RESET_N = 1'b0;
    model_reset();
    #1 check_reset_vals();
    @(negedge clk);
    @(negedge clk);
    RESET_N = 1'b1;
  endtask

  // Monitor: pops an expected event whenever the DUT pulses.
  always @(posedge clk) begin
    #1;
    while (q.size() > 0 && q[0].cyc < cyc) begin
      chk("missing_event_cycle", cyc, q[0].cyc);
      void'(q.pop_front());
    end
    if (tick || time_clr || song_end) begin
      if (q.size() > 0 && q[0].cyc == cyc) begin
        ev_t ev;
        ev = q.pop_front();
        chk("ev_tick", int'(tick), int'(ev.t));
        chk("ev_time_clr", int'(time_clr), int'(ev.c));
        chk("ev_song_end", int'(song_end), int'(ev.e));
        chk("ev_pos", int'(pos_s), ev.pos);
        chk("ev_song", int'(song_sel), ev.song);
        chk("ev_state", int'(state), ev.st);
      end else begin
        chk("unexpected_pulse", int'({tick, time_clr, song_end}), 0);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: bench did not finish, actual timeout required completion");
    $fatal(1);
  end

  initial begin
    int r;
    model_reset();
    m_auto = 0;
    repeat (3) @(negedge clk);
    check_reset_vals();
    RESET_N = 1'b1;

    // 1: single song, autoplay off
    step(1, 0, 0);
    idle(20);

    // 2: autoplay across both songs and back
    m_auto = 1;
    step(1, 0, 0);
    idle(4 * (L0 + L1) + 6);
    step(0, 0, 1);
    idle(2);
    m_auto = 0;

    // 3: pause preserves the partial second
    step(1, 0, 0);
    idle(2);
    step(1, 0, 0);
    idle(20);
    step(1, 0, 0);
    idle(5);
    step(0, 0, 1);
    idle(2);

    // 4: simultaneous buttons, stop wins
    step(1, 0, 0);
    run_to_pos(1);
    idle(1);
    step(1, 1, 1);
    idle(3);

    // 5: next while paused
    if (m_song != 0) step(0, 1, 0);
    step(1, 0, 0);
    run_to_pos(2);
    step(1, 0, 0);
    step(0, 1, 0);
    idle(10);
    step(0, 0, 1);
    idle(2);

    // 6: async reset mid-second
    step(1, 0, 0);
    run_to_pos(2);
    idle(1);
    reset_mid();
    idle(10);
    step(1, 0, 0);
    idle(6);

    // Random traffic
    for (int i = 0; i < 500; i++) begin
      r = $urandom_range(0, 99);
      if (r < 2) m_auto = ~m_auto;
      if (r == 99) reset_mid();
      else step($urandom_range(0, 99) < 6, $urandom_range(0, 99) < 3,
                $urandom_range(0, 99) < 2);
    end

    idle(3);
    chk("queue_drain", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
